mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Parametrised iterative multiply/divide unit with HI/LO result registers. It is the multi-cycle companion to the single-cycle datapath ALU and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO for the MIPS datapath. Operations are launched with a start/busy/done handshake, and a cancel input lets the pipeline squash a speculative operation.

## Interface
- WIDTH, default 32: operand and HI/LO width; must be even and ≥ 4.
- CNT_W, default $clog2(WIDTH)+1: iteration counter width; not overridden in normal use.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  launch request; sampled only when busy=0.
- ctrl  in  3  operation code:
  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO.
  - 110 and 111 are no-ops.
- a  in  WIDTH  rs operand: multiplicand / dividend / MTHI-MTLO source.
- b  in  WIDTH  rt operand: multiplier / divisor.
- cancel  in  1  aborts an in-flight operation.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse; hi/lo hold the new result in the same cycle.
- hi  out  WIDTH  HI register: product upper half, or remainder.
- lo  out  WIDTH  LO register: product lower half, or quotient.

## Operation
- States: IDLE, CALC, FINISH.
- IDLE:
  - start=1 with ctrl 000–011 latches |a|, |b| (magnitudes for the signed ops, raw values for unsigned), latches the result signs, clears the counter, and goes to CALC.
  - start=1 with ctrl=100 writes hi←a at that edge; with ctrl=101 writes lo←a. In both cases done pulses next cycle, busy stays 0 and the state stays IDLE.
  - ctrl 110/111, or start=0: no state change.
- CALC: one iteration per cycle for exactly WIDTH cycles.
  - Multiply: radix-2 shift-add into a 2·WIDTH accumulator.
  - Divide: restoring shift-subtract, giving a WIDTH-bit quotient and remainder.
- FINISH: one cycle.
  - Apply sign correction.
  - Load hi/lo, assert done, return to IDLE.
- Arithmetic rules:
  - MULT/MULTU: {hi,lo} = full 2·WIDTH-bit signed/unsigned product; no overflow is possible.
  - DIV: quotient truncates toward zero; the remainder takes the sign of the dividend.
  - Most-negative ÷ −1: lo = most-negative (wraps), hi = 0.
  - Divide by zero (DIV or DIVU): lo = all ones, hi = a; full latency still applies; no exception.
- cancel:
  - In CALC or FINISH: return to IDLE next edge, busy=0, done is not asserted, hi/lo keep their pre-launch values.
  - In IDLE: no effect, including on a simultaneous start.
- start while busy=1 is ignored; operand inputs are don't-care during CALC.

## Timing
- Reset values: hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0.
- rst during any state aborts the operation and applies the reset values at that edge; rst has priority over cancel and start.
- Multiply/divide latency: start is accepted at edge E0.
  - busy=1 from the cycle after E0 through the cycle before E(WIDTH+1).
  - At E(WIDTH+1) hi/lo update, done=1 and busy=0.
  - Total latency is WIDTH+1 edges (33 for WIDTH=32).
- MTHI/MTLO: register written at E0; done=1 in the following cycle.
- A new start may be accepted in the done cycle, back-to-back; done then falls next cycle unless the new op is MTHI/MTLO.
- hi/lo change only on a FINISH exit, an MTHI/MTLO write, or rst.

## Test plan
- MULT, WIDTH=32:
  - a=0xFFFFFFFE (−2), b=0x00000003 → after 33 edges: done=1, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - Same operands with MULTU → hi=0x00000002, lo=0xFFFFFFFA.
- DIV signed:
  - a=−7 (0xFFFFFFF9), b=2 → lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1).
  - DIVU with a=7, b=2 → lo=3, hi=1.
- Corner divides:
  - DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
  - DIVU a=0x12345678, b=0 → lo=0xFFFFFFFF, hi=0x12345678 after 33 edges.
- Handshake:
  - start held high with MULT through 40 cycles → exactly one op per acceptance, busy low only in done cycles.
  - Back-to-back MULT then DIV in the done cycle → both results correct.
  - MTHI a=0xA5A5A5A5 → hi updates in one edge; done pulses; busy never rises.
- cancel:
  - Preload hi=0x11, lo=0x22 via MTHI/MTLO.
  - Start MULT, assert cancel at CALC cycle 10 → busy=0 next cycle, done never pulses, hi=0x11, lo=0x22.
- Reset:
  - Assert rst at CALC cycle 20 of a DIV → at that edge hi=lo=0, busy=0.
  - A subsequent MULTU 3×5 gives hi=0, lo=15.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// MULT/MULTU use radix-2 shift-add and DIV/DIVU use restoring shift-subtract,
// one iteration per cycle for WIDTH cycles, followed by a sign-fix cycle.
// MTHI/MTLO write the result registers directly from operand a.
//
// Handshake: start is sampled only while busy=0 (state IDLE). An accepted
// multiply/divide holds busy=1 until its done cycle, in which done=1 for
// exactly one cycle and hi/lo already show the new result. cancel squashes
// an in-flight operation without touching hi/lo; rst overrides everything.
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  // Multiply: {partial product upper, multiplier/product lower}.
  // Divide:   {partial remainder, dividend shifting into quotient}.
  logic [2*WIDTH-1:0] r_acc;
  // Multiplicand magnitude for multiply, divisor magnitude for divide.
  logic [WIDTH-1:0]   r_opnd;
  logic               r_is_div;
  logic               r_neg_q;   // negate product / quotient
  logic               r_neg_r;   // negate remainder (sign of dividend)
  logic               r_div0;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_shift;
  logic [WIDTH:0]     w_div_diff;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  // Operand magnitudes and per-iteration datapath.
  always_comb begin
    // Even ctrl codes (MULT, DIV) are the signed operations.
    w_a_neg     = ~ctrl[0] & a[WIDTH-1];
    w_b_neg     = ~ctrl[0] & b[WIDTH-1];
    w_a_mag     = w_a_neg ? -a : a;
    w_b_mag     = w_b_neg ? -b : b;
    w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_div_diff  = w_div_shift - {1'b0, r_opnd};
    w_prod      = r_neg_q ? -r_acc : r_acc;
    // A zero divisor yields an all-ones quotient; the remainder path already
    // reproduces the dividend once its sign is restored.
    w_quo       = r_div0 ? '1 : (r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]);
    w_rem       = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
  end

  // Control FSM, iteration datapath and HI/LO result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            case (ctrl)
              3'b000, 3'b001, 3'b010, 3'b011: begin
                r_state  <= S_CALC;
                r_busy   <= 1'b1;
                r_cnt    <= '0;
                r_is_div <= ctrl[1];
                r_neg_q  <= w_a_neg ^ w_b_neg;
                r_neg_r  <= w_a_neg;
                r_div0   <= ctrl[1] & (b == '0);
                if (ctrl[1]) begin
                  r_acc  <= {{WIDTH{1'b0}}, w_a_mag};
                  r_opnd <= w_b_mag;
                end else begin
                  r_acc  <= {{WIDTH{1'b0}}, w_b_mag};
                  r_opnd <= w_a_mag;
                end
              end
              3'b100: begin
                r_hi   <= a;
                r_done <= 1'b1;
              end
              3'b101: begin
                r_lo   <= a;
                r_done <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        S_CALC: begin
          if (cancel) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            if (r_is_div) begin
              if (!w_div_diff[WIDTH])
                r_acc <= {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
              else
                r_acc <= {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
            end else begin
              r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
            end
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_W'(WIDTH - 1))
              r_state <= S_FINISH;
          end
        end
        S_FINISH: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          if (!cancel) begin
            r_done <= 1'b1;
            if (r_is_div) begin
              r_hi <= w_rem;
              r_lo <= w_quo;
            end else begin
              r_hi <= w_prod[2*WIDTH-1:WIDTH];
              r_lo <= w_prod[WIDTH-1:0];
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign hi        = r_hi;
  assign lo        = r_lo;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed testbench for mul_div_unit (WIDTH=32).
module tb_mul_div_unit;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  ctrl;
  logic [31:0] a;
  logic [31:0] b;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .ctrl(ctrl), .a(a), .b(b),
    .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Driver: called at a negedge. Launches one op, waits (bounded) for done.
  // lat = posedges after acceptance until done (-1 on timeout),
  // bcnt = busy-high cycles before done, d0 = done in the cycle after acceptance.
  task automatic run_op(input logic [2:0] c, input logic [31:0] va, input logic [31:0] vb,
                        output int lat, output int bcnt, output logic d0);
    start = 1'b1; ctrl = c; a = va; b = vb;
    lat = -1; bcnt = 0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    d0 = done;
    if (busy) bcnt++;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        lat = n;
        break;
      end
      if (busy) bcnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; ctrl = 3'b000; a = '0; b = '0; cancel = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if ({hi, lo} !== 64'h0) $display("FAIL reset_hilo got %h exp 0", {hi, lo}); else n_pass++;
    n_checks++; if ({busy, done, dbg_state} !== 4'b0) $display("FAIL reset_ctl got %b exp 0000", {busy, done, dbg_state}); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mult();
    int lat, bcnt; logic d0;
    @(negedge clk);
    run_op(OP_MULT, 32'hFFFFFFFE, 32'h3, lat, bcnt, d0);
    n_checks++; if (lat !== 33) $display("FAIL mult_latency got %0d exp 33", lat); else n_pass++;
    n_checks++; if (bcnt !== 33 || busy !== 1'b0) $display("FAIL mult_busy got %0d/%b exp 33/0", bcnt, busy); else n_pass++;
    n_checks++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFA) $display("FAIL mult_result got %h exp FFFFFFFFFFFFFFFA", {hi, lo}); else n_pass++;
    @(negedge clk);
    n_checks++; if (done !== 1'b0) $display("FAIL mult_done_pulse got %b exp 0", done); else n_pass++;
    run_op(OP_MULTU, 32'hFFFFFFFE, 32'h3, lat, bcnt, d0);
    n_checks++; if ({hi, lo} !== 64'h00000002_FFFFFFFA) $display("FAIL multu_result got %h exp 00000002FFFFFFFA", {hi, lo}); else n_pass++;
    @(negedge clk);
    run_op(OP_MULT, 32'h80000000, 32'h80000000, lat, bcnt, d0);
    n_checks++; if ({hi, lo} !== 64'h40000000_00000000) $display("FAIL mult_minneg got %h exp 4000000000000000", {hi, lo}); else n_pass++;
    @(negedge clk);
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bcnt, d0);
    n_checks++; if ({hi, lo} !== 64'hFFFFFFFE_00000001) $display("FAIL multu_max got %h exp FFFFFFFE00000001", {hi, lo}); else n_pass++;
  endtask

  task automatic test_div();
    int lat, bcnt; logic d0;
    @(negedge clk);
    run_op(OP_DIV, 32'hFFFFFFF9, 32'h2, lat, bcnt, d0);
    n_checks++; if (lat !== 33) $display("FAIL div_latency got %0d exp 33", lat); else n_pass++;
    n_checks++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFD) $display("FAIL div_neg got %h exp FFFFFFFFFFFFFFFD", {hi, lo}); else n_pass++;
    @(negedge clk);
    run_op(OP_DIV, 32'd7, 32'hFFFFFFFE, lat, bcnt, d0);
    n_checks++; if ({hi, lo} !== 64'h00000001_FFFFFFFD) $display("FAIL div_negdivisor got %h exp 00000001FFFFFFFD", {hi, lo}); else n_pass++;
    @(negedge clk);
    run_op(OP_DIVU, 32'd7, 32'd2, lat, bcnt, d0);
    n_checks++; if ({hi, lo} !== 64'h00000001_00000003) $display("FAIL divu got %h exp 0000000100000003", {hi, lo}); else n_pass++;
    @(negedge clk);
    run_op(OP_DIVU, 32'hFFFFFFFF, 32'h10, lat, bcnt, d0);
    n_checks++; if ({hi, lo} !== 64'h0000000F_0FFFFFFF) $display("FAIL divu_big got %h exp 0000000F0FFFFFFF", {hi, lo}); else n_pass++;
  endtask

  task automatic test_div_corner();
    int lat, bcnt; logic d0;
    @(negedge clk);
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, lat, bcnt, d0);
    n_checks++; if ({hi, lo} !== 64'h00000000_80000000) $display("FAIL div_overflow got %h exp 0000000080000000", {hi, lo}); else n_pass++;
    @(negedge clk);
    run_op(OP_DIVU, 32'h12345678, 32'h0, lat, bcnt, d0);
    n_checks++; if (lat !== 33) $display("FAIL divu_zero_latency got %0d exp 33", lat); else n_pass++;
    n_checks++; if ({hi, lo} !== 64'h12345678_FFFFFFFF) $display("FAIL divu_zero got %h exp 12345678FFFFFFFF", {hi, lo}); else n_pass++;
    @(negedge clk);
    run_op(OP_DIV, 32'hFFFFFFF9, 32'h0, lat, bcnt, d0);
    n_checks++; if ({hi, lo} !== 64'hFFFFFFF9_FFFFFFFF) $display("FAIL div_zero got %h exp FFFFFFF9FFFFFFFF", {hi, lo}); else n_pass++;
  endtask

  task automatic test_mthi_mtlo();
    int busy_seen = 0;
    @(negedge clk);
    start = 1'b1; ctrl = OP_MTHI; a = 32'hA5A5A5A5;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    if (busy) busy_seen++;
    n_checks++; if (hi !== 32'hA5A5A5A5) $display("FAIL mthi_value got %h exp A5A5A5A5", hi); else n_pass++;
    n_checks++; if (done !== 1'b1) $display("FAIL mthi_done got %b exp 1", done); else n_pass++;
    @(negedge clk);
    if (busy) busy_seen++;
    n_checks++; if (done !== 1'b0 || busy_seen !== 0) $display("FAIL mthi_pulse got done=%b busy_seen=%0d exp 0/0", done, busy_seen); else n_pass++;
    start = 1'b1; ctrl = OP_MTLO; a = 32'h5A5A0001;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n_checks++; if ({hi, lo, done, busy} !== {32'hA5A5A5A5, 32'h5A5A0001, 2'b10}) $display("FAIL mtlo got %h %h %b%b exp A5A5A5A5 5A5A0001 10", hi, lo, done, busy); else n_pass++;
    start = 1'b1; ctrl = 3'b110; a = 32'hDEADBEEF;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n_checks++; if ({hi, lo, done, busy} !== {32'hA5A5A5A5, 32'h5A5A0001, 2'b00}) $display("FAIL noop got %h %h %b%b exp A5A5A5A5 5A5A0001 00", hi, lo, done, busy); else n_pass++;
  endtask

  task automatic test_cancel();
    int done_seen = 0;
    @(negedge clk);
    start = 1'b1; ctrl = OP_MTHI; a = 32'h11;
    @(negedge clk);
    ctrl = OP_MTLO; a = 32'h22;
    @(negedge clk);
    ctrl = OP_MULT; a = 32'd5; b = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cancel = 1'b0;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL cancel_busy got %b%b exp 00", busy, done); else n_pass++;
    repeat (40) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    n_checks++; if (done_seen !== 0) $display("FAIL cancel_no_done got %0d exp 0", done_seen); else n_pass++;
    n_checks++; if ({hi, lo} !== 64'h00000011_00000022) $display("FAIL cancel_hilo got %h exp 0000001100000022", {hi, lo}); else n_pass++;
  endtask

  task automatic test_reset_mid_op();
    int lat, bcnt; logic d0;
    @(negedge clk);
    start = 1'b1; ctrl = OP_DIV; a = 32'd100; b = 32'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if ({hi, lo, busy, dbg_state} !== 67'h0) $display("FAIL rst_mid got %h %h %b %b exp 0", hi, lo, busy, dbg_state); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(OP_MULTU, 32'd3, 32'd5, lat, bcnt, d0);
    n_checks++; if (lat !== 33 || {hi, lo} !== 64'd15) $display("FAIL rst_then_multu got lat=%0d %h exp 33 000000000000000F", lat, {hi, lo}); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat, bcnt; logic d0;
    @(negedge clk);
    run_op(OP_MULT, 32'd100, 32'hFFFFFFFD, lat, bcnt, d0);
    n_checks++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFED4) $display("FAIL b2b_mult got %h exp FFFFFFFFFFFFFED4", {hi, lo}); else n_pass++;
    // Launch DIV in the MULT done cycle.
    run_op(OP_DIV, 32'd100, 32'd7, lat, bcnt, d0);
    n_checks++; if (d0 !== 1'b0 || bcnt !== 33) $display("FAIL b2b_handshake got d0=%b bcnt=%0d exp 0/33", d0, bcnt); else n_pass++;
    n_checks++; if (lat !== 33 || {hi, lo} !== 64'h00000002_0000000E) $display("FAIL b2b_div got lat=%0d %h exp 33 000000020000000E", lat, {hi, lo}); else n_pass++;
  endtask

  task automatic test_start_held();
    int n_done = 0;
    int bad = 0;
    @(negedge clk);
    start = 1'b1; ctrl = OP_MULT; a = 32'd3; b = 32'd4;
    repeat (80) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        n_done++;
        if ({hi, lo} !== 64'd12) bad++;
      end
      if (busy === done) bad++;
    end
    start = 1'b0;
    n_checks++; if (n_done !== 2) $display("FAIL held_done_count got %0d exp 2", n_done); else n_pass++;
    n_checks++; if (bad !== 0) $display("FAIL held_busy_done got %0d bad cycles exp 0", bad); else n_pass++;
    for (int i = 0; i < 60 && busy; i++) @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL held_drain got busy=%b exp 0", busy); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_corner();
    test_mthi_mtlo();
    test_cancel();
    test_reset_mid_op();
    test_back_to_back();
    test_start_held();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
